// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the two-port UART controller.
//   SRC_PORT1 / SRC_PORT2 : source codes carried in the top bits of a header
//   LEN_W                 : width of the length field of a header
//   merger_state_t        : state encoding of the return-path packet merger
//   pack_header / header_src / header_len : header byte build and split helpers
// The downstream command parser uses the same header helpers, so both
// directions of traffic share one framing.
package uart_ctrl_pkg;

  localparam logic [1:0] SRC_PORT1 = 2'b00;
  localparam logic [1:0] SRC_PORT2 = 2'b01;
  localparam int         LEN_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HWAIT,
    ST_DISSUE,
    ST_DWAIT
  } merger_state_t;

  function automatic logic [7:0] pack_header(input logic [1:0]       src,
                                             input logic [LEN_W-1:0] len);
    return {src, len};
  endfunction

  function automatic logic [1:0] header_src(input logic [7:0] hdr);
    return hdr[7:6];
  endfunction

  function automatic logic [LEN_W-1:0] header_len(input logic [7:0] hdr);
    return hdr[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en     : push wr_data (ignored when full unless a pop happens in the same cycle)
//   wr_data   : byte to push
//   rd_en     : pop the head byte (ignored when empty)
//   rd_data   : current head byte, valid whenever empty is low
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of bytes held, 0..DEPTH
module uart_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_wr && !do_rd) begin
        count <= count + (AW+1)'(1);
      end else if (do_rd && !do_wr) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_packet_merger.sv
// Return path of the two-port UART controller. Bytes received on port 1 and
// port 2 are queued per port and sent out over one UART_TX as packets of
// {src, len} header followed by len data bytes.
//   clk, rst          : clock, asynchronous active-high reset
//   rx1_dv, rx1_byte  : port 1 received byte strobe and data
//   rx2_dv, rx2_byte  : port 2 received byte strobe and data
//   tx_dv, tx_byte    : byte launch strobe and data to UART_TX
//   tx_done           : UART_TX finished the byte in flight
//   drop1, drop2      : pulse when a byte was discarded on a full FIFO
//   led_command       : header byte in flight
//   led_data          : data byte in flight
module uart_packet_merger
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 64,
  parameter int MAX_LEN     = 63,
  parameter int IDLE_CYCLES = 8700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx1_dv,
  input  logic [7:0] rx1_byte,
  input  logic       rx2_dv,
  input  logic [7:0] rx2_byte,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       drop1,
  output logic       drop2,
  output logic       led_command,
  output logic       led_data
);

  localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int             TW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_LEN);
  localparam logic [TW-1:0]  IDLE_MAX = TW'(IDLE_CYCLES);

  merger_state_t        state;
  logic                 sel;
  logic                 prefer_p2;
  logic [LEN_W-1:0]     len;
  logic [LEN_W-1:0]     remaining;

  logic [1:0]           rx_dv;
  logic [1:0][7:0]      rx_byte;
  logic [1:0][7:0]      head;
  logic [1:0][CW-1:0]   count;
  logic [1:0]           full_flag;
  logic [1:0]           empty_flag;
  logic [1:0]           pop;
  logic [1:0]           drop_now;
  logic [1:0]           ready;
  logic [1:0]           launch;

  logic                 pick_valid;
  logic                 pick;
  logic [CW-1:0]        pick_count;
  logic [LEN_W-1:0]     launch_len;

  assign rx_dv    = {rx2_dv, rx1_dv};
  assign rx_byte  = {rx2_byte, rx1_byte};
  assign pop[0]   = (state == ST_DISSUE) && !sel;
  assign pop[1]   = (state == ST_DISSUE) && sel;
  // A pop always hits a non-empty FIFO, so full plus pop means the write fits.
  assign drop_now = rx_dv & full_flag & ~pop;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [TW-1:0] timer;

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (rx_dv[p]),
      .wr_data (rx_byte[p]),
      .rd_en   (pop[p]),
      .rd_data (head[p]),
      .full    (full_flag[p]),
      .empty   (empty_flag[p]),
      .count   (count[p])
    );

    // Quiet-time counter: restarts on each accepted byte and on launch,
    // otherwise counts up to IDLE_MAX while bytes are waiting.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        timer <= '0;
      end else if ((rx_dv[p] && !drop_now[p]) || launch[p]) begin
        timer <= '0;
      end else if (!empty_flag[p] && timer != IDLE_MAX) begin
        timer <= timer + TW'(1);
      end
    end

    assign ready[p] = (count[p] >= MAX_CNT) || (count[p] != '0 && timer == IDLE_MAX);
  end

  // Round-robin choice: only a tie consults the pointer.
  always_comb begin
    pick_valid = ready[0] || ready[1];
    if (ready[0] && ready[1]) begin
      pick = prefer_p2;
    end else begin
      pick = ready[1];
    end
    pick_count = pick ? count[1] : count[0];
    launch_len = (pick_count >= MAX_CNT) ? LEN_W'(MAX_LEN) : LEN_W'(pick_count);
    launch     = 2'b00;
    if (state == ST_IDLE && pick_valid) begin
      launch = pick ? 2'b10 : 2'b01;
    end
  end

  // Packet sequencer; tx_dv is a one-cycle strobe, tx_byte holds until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= 1'b0;
      prefer_p2   <= 1'b0;
      len         <= '0;
      remaining   <= '0;
      tx_dv       <= 1'b0;
      tx_byte     <= '0;
      led_command <= 1'b0;
      led_data    <= 1'b0;
    end else begin
      tx_dv <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            sel   <= pick;
            len   <= launch_len;
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          tx_byte     <= pack_header(sel ? SRC_PORT2 : SRC_PORT1, len);
          tx_dv       <= 1'b1;
          led_command <= 1'b1;
          state       <= ST_HWAIT;
        end
        ST_HWAIT: begin
          if (tx_done) begin
            led_command <= 1'b0;
            remaining   <= len;
            state       <= ST_DISSUE;
          end
        end
        ST_DISSUE: begin
          tx_byte   <= head[sel];
          tx_dv     <= 1'b1;
          led_data  <= 1'b1;
          remaining <= remaining - LEN_W'(1);
          state     <= ST_DWAIT;
        end
        ST_DWAIT: begin
          if (tx_done) begin
            led_data <= 1'b0;
            if (remaining == '0) begin
              prefer_p2 <= ~sel;
              state     <= ST_IDLE;
            end else begin
              state <= ST_DISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop1 <= 1'b0;
      drop2 <= 1'b0;
    end else begin
      drop1 <= drop_now[0];
      drop2 <= drop_now[1];
    end
  end

endmodule
